jump_unit_ctrl: RTL



---
 rtl/jump_unit_ctrl_pkg.sv | 28 ++
 rtl/jump_unit_ctrl_sat_counter.sv | 34 +++
 rtl/jump_unit_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/jump_unit_ctrl_pkg.sv
// Shared definitions for the jump/branch unit sequencing controller.
//   kind_e    : control-transfer kind as presented by issue
//   state_e   : controller FSM states
//   is_link_kind() : true for kinds that produce a link value (JAL/JALR)
package jump_unit_ctrl_pkg;

  typedef enum logic [1:0] {
    KIND_BR   = 2'd0,
    KIND_JAL  = 2'd1,
    KIND_JALR = 2'd2,
    KIND_RSVD = 2'd3   // decoded as a plain branch, never written back
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_WB      = 2'd3
  } state_e;

  // Width of the FU latency down-counter; holds LAT-1 for LAT up to 7.
  localparam int LAT_CNT_W = 3;

  function automatic logic is_link_kind(input logic [1:0] kind);
    return (kind == KIND_JAL) || (kind == KIND_JALR);
  endfunction

endpackage

// File: rtl/jump_unit_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   inc      : count one event this cycle
//   count    : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/jump_unit_ctrl.sv
// Sequencing controller for the jump/branch functional unit.
// Accepts one control-transfer op at a time, waits the FU latency, resolves
// taken/not-taken, pulses redirect/flush, and hands the link value to the
// writeback stage over a req/grant handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   issue_valid/issue_ready       issue handshake; transfer when both high
//   issue_kind, issue_rd          op kind and link destination
//   fu_en, fu_jalr                FU capture enable and JALR select
//   fu_cmp_res, fu_pc_jump, fu_pc_wb  FU results, valid in RESOLVE
//   squash                        kills the in-flight op
//   redirect_valid/pc, flush      one-cycle pulse on a taken transfer
//   wb_req/wb_rd/wb_data/wb_grant writeback handshake
//   busy                          op in flight
//   cnt_resolved, cnt_taken       saturating performance counters
//
// Handshakes: issue transfers on a clock edge where issue_valid & issue_ready.
// wb_req/wb_rd/wb_data stay stable from entering WB until the edge where
// wb_grant is high; that edge performs the write.
module jump_unit_ctrl
  import jump_unit_ctrl_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_kind,
  input  logic [4:0]       issue_rd,
  output logic             fu_en,
  output logic             fu_jalr,
  input  logic             fu_cmp_res,
  input  logic [31:0]      fu_pc_jump,
  input  logic [31:0]      fu_pc_wb,
  input  logic             squash,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             wb_req,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  input  logic             wb_grant,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_taken
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LAT - 1);

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [1:0]           kind_q, kind_d;
  logic [4:0]           rd_q, rd_d;
  logic [31:0]          wb_data_q, wb_data_d;

  logic resolve_live;
  logic taken;
  logic inc_resolved;
  logic inc_taken;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    kind_d       = kind_q;
    rd_d         = rd_q;
    wb_data_d    = wb_data_q;

    issue_ready  = (state_q == ST_IDLE) && !squash;
    fu_en        = issue_valid && issue_ready;
    fu_jalr      = (issue_kind == KIND_JALR);

    // Reserved kind falls into the branch path: only link kinds are
    // unconditionally taken.
    resolve_live = (state_q == ST_RESOLVE) && !squash;
    taken        = is_link_kind(kind_q) || fu_cmp_res;
    inc_resolved = resolve_live;
    inc_taken    = resolve_live && taken;

    case (state_q)
      ST_IDLE: begin
        if (fu_en) begin
          kind_d  = issue_kind;
          rd_d    = issue_rd;
          lat_d   = LAT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Count is loaded with LAT-1, so RESOLVE is entered LAT edges
        // after capture, when the FU outputs are valid.
        if (squash) begin
          state_d = ST_IDLE;
        end else if (lat_q == '0) begin
          state_d = ST_RESOLVE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESOLVE: begin
        if (squash) begin
          state_d = ST_IDLE;
        end else begin
          wb_data_d = fu_pc_wb;
          if (is_link_kind(kind_q) && (rd_q != 5'd0)) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WB: begin
        // A grant in the same cycle as squash still completes the write.
        if (wb_grant || squash) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      kind_q    <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      kind_q    <= kind_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign redirect_valid = inc_taken;
  assign flush          = inc_taken;
  assign redirect_pc    = fu_pc_jump;
  assign wb_req         = (state_q == ST_WB);
  assign wb_rd          = rd_q;
  assign wb_data        = wb_data_q;
  assign busy           = (state_q != ST_IDLE);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_resolved (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_resolved),
    .count (cnt_resolved)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_taken),
    .count (cnt_taken)
  );

endmodule
